// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the backing memory.
// Signal names keep the arbiter's point of view (i_* into the arbiter,
// o_* out of it).
//   slave  : arbiter side (reads i_*, drives o_*)
//   master : requester/memory side (drives i_*, reads o_*)
//   fetch  : i_if_req_valid, i_if_addr / o_if_req_ready, o_if_res_valid, o_if_rdata
//   data   : i_d_req_valid, i_d_addr, i_d_we, i_d_be, i_d_wdata /
//            o_d_req_ready, o_d_res_valid, o_d_rdata
//   memory : o_m_req_valid, o_m_addr, o_m_we, o_m_be, o_m_wdata /
//            i_m_req_ready, i_m_res_valid, i_m_rdata
//   status : o_busy, o_owner, o_err
interface cpu_mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned BE_W = XLEN / 8;

  logic            i_if_req_valid;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_req_ready;
  logic            o_if_res_valid;
  logic [XLEN-1:0] o_if_rdata;

  logic            i_d_req_valid;
  logic [XLEN-1:0] i_d_addr;
  logic            i_d_we;
  logic [BE_W-1:0] i_d_be;
  logic [XLEN-1:0] i_d_wdata;
  logic            o_d_req_ready;
  logic            o_d_res_valid;
  logic [XLEN-1:0] o_d_rdata;

  logic            o_m_req_valid;
  logic            i_m_req_ready;
  logic [XLEN-1:0] o_m_addr;
  logic [XLEN-1:0] o_m_wdata;
  logic            o_m_we;
  logic [BE_W-1:0] o_m_be;
  logic            i_m_res_valid;
  logic [XLEN-1:0] i_m_rdata;

  logic            o_busy;
  logic            o_owner;
  logic            o_err;

  modport slave (
    input  i_if_req_valid, i_if_addr,
    output o_if_req_ready, o_if_res_valid, o_if_rdata,
    input  i_d_req_valid, i_d_addr, i_d_we, i_d_be, i_d_wdata,
    output o_d_req_ready, o_d_res_valid, o_d_rdata,
    output o_m_req_valid, o_m_addr, o_m_wdata, o_m_we, o_m_be,
    input  i_m_req_ready, i_m_res_valid, i_m_rdata,
    output o_busy, o_owner, o_err
  );

  modport master (
    output i_if_req_valid, i_if_addr,
    input  o_if_req_ready, o_if_res_valid, o_if_rdata,
    output i_d_req_valid, i_d_addr, i_d_we, i_d_be, i_d_wdata,
    input  o_d_req_ready, o_d_res_valid, o_d_rdata,
    input  o_m_req_valid, o_m_addr, o_m_wdata, o_m_we, o_m_be,
    output i_m_req_ready, i_m_res_valid, i_m_rdata,
    input  o_busy, o_owner, o_err
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the MEM-stage data requester. One transaction outstanding at a time;
// responses go only to the requester that owns the transaction.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   arb_if  : cpu_mem_arbiter_if.slave (fetch, data, memory and status buses)
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that ends a
// transaction after TIMEOUT_CYCLES cycles with o_err and rdata 0xDEADBEEF.
module cpu_mem_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  cpu_mem_arbiter_if.slave arb_if
);

  localparam int unsigned BE_W = XLEN / 8;
  localparam logic [XLEN-1:0] TMO_RDATA = XLEN'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e          state_q;
  logic            owner_q;   // 0 = fetch, 1 = data; doubles as last_grant
  logic            we_q;      // owner is a data write (rdata forced to 0)

  logic            in_issue_c;
  logic            in_wait_c;
  logic            any_req_c;
  logic            grant_c;
  logic            accept_c;
  logic            resp_c;
  logic            tmo_c;
  logic            done_c;
  logic            ready_c;
  logic [XLEN-1:0] rsp_data_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // Transaction events; reset masks everything so nothing leaks out mid-reset.
  always_comb begin
    in_issue_c = (state_q == ST_ISSUE) & ~i_reset;
    in_wait_c  = (state_q == ST_WAIT)  & ~i_reset;
    any_req_c  = arb_if.i_if_req_valid | arb_if.i_d_req_valid;
    // Tie goes to whoever was not granted last; otherwise the lone requester.
    if (arb_if.i_if_req_valid && arb_if.i_d_req_valid) begin
      grant_c = ~owner_q;
    end else begin
      grant_c = arb_if.i_d_req_valid;
    end
    accept_c = in_issue_c & arb_if.i_m_req_ready;
    resp_c   = (accept_c & arb_if.i_m_res_valid) | (in_wait_c & arb_if.i_m_res_valid);
`ifdef MEM_ARB_TIMEOUT_EN
    // Fires in the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT; a real
    // response in that same cycle wins.
    tmo_c = (in_issue_c | in_wait_c) & ~resp_c &
            (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog absent; the parameter stays referenced so both builds match.
    tmo_c = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
    done_c  = resp_c | tmo_c;
    // A timeout in ISSUE still owes the requester its accept pulse.
    ready_c = accept_c | (tmo_c & in_issue_c);
    if (tmo_c) begin
      rsp_data_c = TMO_RDATA;
    end else if (owner_q && we_q) begin
      rsp_data_c = '0;
    end else begin
      rsp_data_c = arb_if.i_m_rdata;
    end
  end

  // Memory bus mux and requester handshakes.
  always_comb begin
    arb_if.o_m_req_valid  = 1'b0;
    arb_if.o_m_addr       = '0;
    arb_if.o_m_wdata      = '0;
    arb_if.o_m_we         = 1'b0;
    arb_if.o_m_be         = '0;
    arb_if.o_if_req_ready = 1'b0;
    arb_if.o_if_res_valid = 1'b0;
    arb_if.o_if_rdata     = '0;
    arb_if.o_d_req_ready  = 1'b0;
    arb_if.o_d_res_valid  = 1'b0;
    arb_if.o_d_rdata      = '0;
    if (in_issue_c) begin
      arb_if.o_m_req_valid = 1'b1;
      if (owner_q) begin
        arb_if.o_m_addr  = arb_if.i_d_addr;
        arb_if.o_m_wdata = arb_if.i_d_wdata;
        arb_if.o_m_we    = arb_if.i_d_we;
        arb_if.o_m_be    = arb_if.i_d_be;
      end else begin
        arb_if.o_m_addr  = arb_if.i_if_addr;
        arb_if.o_m_be    = {BE_W{1'b1}};
      end
    end
    if (owner_q) begin
      arb_if.o_d_req_ready = ready_c;
      arb_if.o_d_res_valid = done_c;
      if (done_c) arb_if.o_d_rdata = rsp_data_c;
    end else begin
      arb_if.o_if_req_ready = ready_c;
      arb_if.o_if_res_valid = done_c;
      if (done_c) arb_if.o_if_rdata = rsp_data_c;
    end
    arb_if.o_busy  = in_issue_c | in_wait_c;
    arb_if.o_owner = owner_q & ~i_reset;
    arb_if.o_err   = tmo_c;
  end

  // Arbitration FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req_c) begin
            owner_q <= grant_c;
            we_q    <= grant_c & arb_if.i_d_we;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (done_c) begin
            state_q <= ST_IDLE;
          end else if (accept_c) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog: zero while idle (so it restarts on entering ISSUE), counts otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset || state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter_if #(.XLEN(32)) bus ();

  cpu_mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .arb_if  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then drive.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well away from edges).
  task automatic settle();
    #3;
  endtask

  task automatic mem_idle();
    bus.i_m_req_ready = 1'b0;
    bus.i_m_res_valid = 1'b0;
    bus.i_m_rdata     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.i_if_req_valid = 1'b0;
    bus.i_if_addr      = '0;
    bus.i_d_req_valid  = 1'b0;
    bus.i_d_addr       = '0;
    bus.i_d_we         = 1'b0;
    bus.i_d_be         = '0;
    bus.i_d_wdata      = '0;
    mem_idle();

    // Reset state
    next(); next();
    settle();
    chk("rst_busy",   bus.o_busy, 0);
    chk("rst_owner",  bus.o_owner, 0);
    chk("rst_mvalid", bus.o_m_req_valid, 0);
    chk("rst_ifres",  bus.o_if_res_valid, 0);
    chk("rst_dres",   bus.o_d_res_valid, 0);
    chk("rst_err",    bus.o_err, 0);
    next();
    rst = 1'b0;

    // Single fetch: ready 2 cycles into ISSUE, response 3 cycles later
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h100;
    settle();
    chk("f_idle_mvalid", bus.o_m_req_valid, 0);
    next(); settle();
    chk("f_mvalid", bus.o_m_req_valid, 1);
    chk("f_maddr",  bus.o_m_addr, 32'h100);
    chk("f_mbe",    bus.o_m_be, 32'hF);
    chk("f_mwe",    bus.o_m_we, 0);
    chk("f_owner",  bus.o_owner, 0);
    chk("f_rdy_early", bus.o_if_req_ready, 0);
    next(); settle();
    chk("f_rdy_early2", bus.o_if_req_ready, 0);
    next();
    bus.i_m_req_ready = 1'b1;
    settle();
    chk("f_ifrdy", bus.o_if_req_ready, 1);
    chk("f_drdy",  bus.o_d_req_ready, 0);
    next();
    bus.i_if_req_valid = 1'b0;
    mem_idle();
    settle();
    chk("f_wait_mvalid", bus.o_m_req_valid, 0);
    chk("f_wait_busy",   bus.o_busy, 1);
    chk("f_wait_ifrdy",  bus.o_if_req_ready, 0);
    next(); next();
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'h0050_0093;
    settle();
    chk("f_ifres",   bus.o_if_res_valid, 1);
    chk("f_ifrdata", bus.o_if_rdata, 32'h0050_0093);
    chk("f_dres",    bus.o_d_res_valid, 0);
    next();
    mem_idle();
    settle();
    chk("f_done_busy",  bus.o_busy, 0);
    chk("f_done_ifres", bus.o_if_res_valid, 0);

    // First tie after reset goes to data
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h300;
    bus.i_d_req_valid  = 1'b1;
    bus.i_d_addr       = 32'h2000;
    bus.i_d_we         = 1'b0;
    bus.i_d_be         = 4'hF;
    settle();
    chk("tie_idle_busy", bus.o_busy, 0);
    next();
    bus.i_m_req_ready = 1'b1;
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'h1111_2222;
    settle();
    chk("tie1_owner", bus.o_owner, 1);
    chk("tie1_maddr", bus.o_m_addr, 32'h2000);
    chk("tie1_drdy",  bus.o_d_req_ready, 1);
    chk("tie1_dres",  bus.o_d_res_valid, 1);
    chk("tie1_drd",   bus.o_d_rdata, 32'h1111_2222);
    chk("tie1_ifrdy", bus.o_if_req_ready, 0);
    chk("tie1_ifres", bus.o_if_res_valid, 0);
    next();
    bus.i_d_req_valid = 1'b0;
    mem_idle();
    settle();
    chk("tie_gap_busy",  bus.o_busy, 0);
    chk("tie_gap_owner", bus.o_owner, 1);
    next();
    bus.i_m_req_ready = 1'b1;
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'h3333_4444;
    settle();
    chk("tie2_owner", bus.o_owner, 0);
    chk("tie2_maddr", bus.o_m_addr, 32'h300);
    chk("tie2_ifres", bus.o_if_res_valid, 1);
    chk("tie2_ifrd",  bus.o_if_rdata, 32'h3333_4444);
    chk("tie2_dres",  bus.o_d_res_valid, 0);
    next();
    bus.i_if_req_valid = 1'b0;
    mem_idle();

    // Fairness: both held valid, expected order D I D I D I
    bus.i_if_req_valid = 1'b1;
    bus.i_d_req_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rr_idle_busy", bus.o_busy, 0);
      next();
      bus.i_m_req_ready = 1'b1;
      bus.i_m_res_valid = 1'b1;
      bus.i_m_rdata     = 32'hA000_0000 + 32'(k);
      settle();
      if (k % 2 == 0) begin
        chk("rr_owner_d", bus.o_owner, 1);
        chk("rr_maddr_d", bus.o_m_addr, 32'h2000);
        chk("rr_dres",    bus.o_d_res_valid, 1);
        chk("rr_ifres_q", bus.o_if_res_valid, 0);
        chk("rr_drd",     bus.o_d_rdata, 32'hA000_0000 + 32'(k));
      end else begin
        chk("rr_owner_i", bus.o_owner, 0);
        chk("rr_maddr_i", bus.o_m_addr, 32'h300);
        chk("rr_ifres",   bus.o_if_res_valid, 1);
        chk("rr_dres_q",  bus.o_d_res_valid, 0);
        chk("rr_ifrd",    bus.o_if_rdata, 32'hA000_0000 + 32'(k));
      end
      next();
      mem_idle();
    end
    bus.i_if_req_valid = 1'b0;
    bus.i_d_req_valid  = 1'b0;

    // Data write with partial byte enables
    bus.i_d_req_valid = 1'b1;
    bus.i_d_addr      = 32'h40;
    bus.i_d_we        = 1'b1;
    bus.i_d_be        = 4'b0011;
    bus.i_d_wdata     = 32'hCAFE_1234;
    next();
    bus.i_m_req_ready = 1'b1;
    settle();
    chk("w_mwe",    bus.o_m_we, 1);
    chk("w_mbe",    bus.o_m_be, 32'h3);
    chk("w_mwdata", bus.o_m_wdata, 32'hCAFE_1234);
    chk("w_maddr",  bus.o_m_addr, 32'h40);
    chk("w_drdy",   bus.o_d_req_ready, 1);
    chk("w_dres_early", bus.o_d_res_valid, 0);
    next();
    bus.i_d_req_valid = 1'b0;
    bus.i_m_req_ready = 1'b0;
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'hFFFF_FFFF;
    settle();
    chk("w_wait_mwdata", bus.o_m_wdata, 0);
    chk("w_wait_mbe",    bus.o_m_be, 0);
    chk("w_dres",  bus.o_d_res_valid, 1);
    chk("w_drd",   bus.o_d_rdata, 0);
    chk("w_ifres", bus.o_if_res_valid, 0);
    next();
    mem_idle();
    bus.i_d_we    = 1'b0;
    bus.i_d_be    = '0;
    bus.i_d_wdata = '0;

    // Reset while in WAIT; a late memory response must be ignored
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h500;
    next();
    bus.i_m_req_ready = 1'b1;
    settle();
    chk("r_ifrdy", bus.o_if_req_ready, 1);
    next();
    bus.i_if_req_valid = 1'b0;
    bus.i_m_req_ready  = 1'b0;
    settle();
    chk("r_wait_busy", bus.o_busy, 1);
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'h1234;
    settle();
    chk("r_late_ifres", bus.o_if_res_valid, 0);
    chk("r_late_dres",  bus.o_d_res_valid, 0);
    chk("r_late_busy",  bus.o_busy, 0);
    chk("r_late_owner", bus.o_owner, 0);
    next();
    mem_idle();
    settle();
    chk("r_after_busy",   bus.o_busy, 0);
    chk("r_after_mvalid", bus.o_m_req_valid, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: memory never answers; fires in the 8th busy cycle
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h600;
    next();
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("t_err_early",   bus.o_err, 0);
      chk("t_ifres_early", bus.o_if_res_valid, 0);
      next();
    end
    settle();
    chk("t_err",   bus.o_err, 1);
    chk("t_ifrdy", bus.o_if_req_ready, 1);
    chk("t_ifres", bus.o_if_res_valid, 1);
    chk("t_ifrd",  bus.o_if_rdata, 32'hDEAD_BEEF);
    chk("t_dres",  bus.o_d_res_valid, 0);
    next();
    bus.i_if_req_valid = 1'b0;
    settle();
    chk("t_idle_busy", bus.o_busy, 0);
    chk("t_idle_err",  bus.o_err, 0);
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h700;
    next();
    bus.i_m_req_ready = 1'b1;
    bus.i_m_res_valid = 1'b1;
    bus.i_m_rdata     = 32'h0000_ABCD;
    settle();
    chk("t_next_maddr", bus.o_m_addr, 32'h700);
    chk("t_next_ifres", bus.o_if_res_valid, 1);
    chk("t_next_ifrd",  bus.o_if_rdata, 32'h0000_ABCD);
    chk("t_next_err",   bus.o_err, 0);
    next();
    bus.i_if_req_valid = 1'b0;
    mem_idle();
`else
    // Without the watchdog a stalled transaction never errors out
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h600;
    next();
    for (int i = 0; i < 12; i++) next();
    settle();
    chk("nt_err",   bus.o_err, 0);
    chk("nt_ifres", bus.o_if_res_valid, 0);
    chk("nt_busy",  bus.o_busy, 1);
    chk("nt_mvalid", bus.o_m_req_valid, 1);
    rst = 1'b1;
    bus.i_if_req_valid = 1'b0;
    next();
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the data-memory (MEM stage) requester of the multi-cycle RV CPU.
- Allows one outstanding transaction at a time and uses round-robin arbitration.
- Routes each response only to the requester that issued it.
- Sits between the fetch/memory units and the single backing memory (or the later cache).

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_if_req_valid  in  1  fetch read request; held until o_if_req_ready.
- i_if_addr  in  XLEN  fetch address; stable while valid.
- o_if_req_ready  out  1  one-cycle pulse when the memory accepts the fetch request.
- o_if_res_valid  out  1  one-cycle pulse when fetch read data is returned.
- o_if_rdata  out  XLEN  fetch read data; valid with o_if_res_valid.
- i_d_req_valid  in  1  data request; held until o_d_req_ready.
- i_d_addr  in  XLEN  data address.
- i_d_we  in  1  1 = write, 0 = read.
- i_d_be  in  XLEN/8  byte enables.
- i_d_wdata  in  XLEN  write data.
- o_d_req_ready  out  1  one-cycle accept pulse.
- o_d_res_valid  out  1  one-cycle completion pulse; asserted for writes too.
- o_d_rdata  out  XLEN  read data; 0 for writes.
- o_m_req_valid  out  1  request to memory.
- i_m_req_ready  in  1  memory accepts the request.
- o_m_addr, o_m_wdata  out  XLEN  request address and write data.
- o_m_we  out  1  request write enable.
- o_m_be  out  XLEN/8  request byte enables.
- i_m_res_valid  in  1  memory response strobe.
- i_m_rdata  in  XLEN  memory read data.
- o_busy  out  1  asserted in any state other than IDLE.
- o_owner  out  1  current or last grant; 0 = fetch, 1 = data.
- o_err  out  1  timeout pulse; tied 0 when MEM_ARB_TIMEOUT_EN is not defined.

Behaviour:
- Reset:
  - state = IDLE, last_grant = fetch (0).
  - All outputs 0.
  - Reset overrides everything, including mid-transaction. The outstanding transaction is abandoned with no response pulse to either requester.
  - A late i_m_res_valid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not last_grant. The first tie after reset therefore goes to data.
  - On a grant: register owner, update last_grant, go to ISSUE next cycle.
  - No grant when neither requester is valid.
- ISSUE:
  - o_m_req_valid = 1.
  - o_m_addr, o_m_we, o_m_be and o_m_wdata are driven combinationally from the owner's inputs.
  - Fetch requests drive we = 0, be = all ones, wdata = 0.
  - On i_m_req_ready: pulse the owner's req_ready and go to WAIT.
  - If i_m_res_valid is also high in the same cycle, complete immediately: pulse the owner's res_valid and go to IDLE.
- WAIT:
  - o_m_req_valid = 0.
  - On i_m_res_valid: drive the owner's res_valid for one cycle with rdata = i_m_rdata (0 for a data write), then go to IDLE.
- Memory bus idle values: o_m_* outputs are 0 outside ISSUE.
- Response routing: the non-owner's res_valid and ready never assert.
- Minimum latency: request valid in cycle N → o_m_req_valid in N+1 → earliest response in N+1 (combined accept and response) → requester sees res_valid in the same cycle.
- Back-to-back: after a completion, one IDLE cycle precedes the next grant.
- Requester misbehaviour: a requester deasserting valid while in ISSUE is a protocol violation. The arbiter keeps issuing the latched owner's request.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter resets on entering ISSUE and counts while in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES: pulse o_err and the owner's res_valid with rdata = 32'hDEAD_BEEF, then go to IDLE.
  - If the owner's req_ready has not yet pulsed, it pulses in the same cycle.
- When not defined: no counter, o_err tied 0, and WAIT lasts indefinitely.

Test Plan:
- Single fetch: reset, i_if_req_valid with addr 0x100, memory ready after 2 cycles, rdata 0x00500093 after 3 more → o_if_req_ready pulses once, then o_if_res_valid with 0x00500093; o_d_res_valid stays 0.
- First tie after reset: both requesters valid in the same cycle → data (addr 0x2000, read) is issued first, then fetch; o_owner = 1 then 0.
- Fairness: both requesters held valid for 6 transactions → issue order D, I, D, I, D, I.
- Data write: we = 1, be = 4'b0011, wdata 0xCAFE1234 → o_m_be = 0011, o_m_wdata = 0xCAFE1234, o_d_rdata = 0 on completion.
- Reset mid-transaction: i_reset asserted in WAIT, then memory responds afterwards → no res_valid on either requester, state IDLE, o_busy = 0.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): memory never responds → o_err and o_if_res_valid pulse with rdata 0xDEADBEEF after 8 cycles, and the next request is served normally.
